// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request and memory bus bundle for mem_access_ctrl
interface mem_access_ctrl_if;
    logic        req;
    logic        we;
    logic        byte_op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic [15:0] rdata;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport slave (
        input  req, we, byte_op, addr, wdata, mem_rdata,
        output busy, done, rdata, mem_write, mem_read, mem_addr, mem_wdata
    );

    modport master (
        output req, we, byte_op, addr, wdata, mem_rdata,
        input  busy, done, rdata, mem_write, mem_read, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-request memory access sequencer with registered strobes
// Byte access and the read-modify-write byte store exist only when BYTE_LANE_EN is defined.
module mem_access_ctrl (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  io_bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
`ifdef BYTE_LANE_EN
        RMW_RD,
        RMW_WAIT,
        RMW_WR,
`endif
        DONE
    } state_t;

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_rdata;
    logic        r_mem_write;
    logic        r_mem_read;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
`ifdef BYTE_LANE_EN
    logic        r_byte_op;
    logic [7:0]  r_wdata;
`endif

    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.rdata     = r_rdata;
    assign io_bus.mem_write = r_mem_write;
    assign io_bus.mem_read  = r_mem_read;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = r_mem_wdata;

    // Bus encoding is inverted from the names: mem_write marks a load, mem_read a store.
    // Strobes are set on the edge entering the issue state, so they live for that state only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rdata     <= 16'h0000;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 16'h0000;
`ifdef BYTE_LANE_EN
            r_byte_op   <= 1'b0;
            r_wdata     <= 8'h00;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.req) begin
                        r_busy     <= 1'b1;
                        r_mem_addr <= io_bus.addr;
`ifdef BYTE_LANE_EN
                        r_byte_op  <= io_bus.byte_op;
                        r_wdata    <= io_bus.wdata[7:0];
`endif
                        if (!io_bus.we) begin
                            r_mem_write <= 1'b1;
                            r_state     <= RD_ISSUE;
                        end
`ifdef BYTE_LANE_EN
                        else if (io_bus.byte_op) begin
                            r_mem_write <= 1'b1;
                            r_state     <= RMW_RD;
                        end
`endif
                        else begin
                            r_mem_read  <= 1'b1;
                            r_mem_wdata <= io_bus.wdata;
                            r_state     <= WR_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    r_mem_write <= 1'b0;
                    r_state     <= RD_WAIT;
                end
                RD_WAIT: begin
`ifdef BYTE_LANE_EN
                    r_rdata <= r_byte_op ? {8'h00, io_bus.mem_rdata[7:0]} : io_bus.mem_rdata;
`else
                    r_rdata <= io_bus.mem_rdata;
`endif
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                WR_ISSUE: begin
                    r_mem_read <= 1'b0;
                    r_done     <= 1'b1;
                    r_state    <= DONE;
                end
`ifdef BYTE_LANE_EN
                RMW_RD: begin
                    r_mem_write <= 1'b0;
                    r_state     <= RMW_WAIT;
                end
                RMW_WAIT: begin
                    // Upper byte keeps its memory value; only the addressed byte changes.
                    r_mem_wdata <= {io_bus.mem_rdata[15:8], r_wdata};
                    r_mem_read  <= 1'b1;
                    r_state     <= RMW_WR;
                end
                RMW_WR: begin
                    r_mem_read <= 1'b0;
                    r_done     <= 1'b1;
                    r_state    <= DONE;
                end
`endif
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_mem_read  <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk (rising edge), rst (active-high, asynchronous).
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req  input  1  datapath request strobe; sampled only when busy=0.
REQ-005 we  input  1  1=store, 0=load; sampled with req.
REQ-006 byte_op  input  1  1=byte access; sampled with req.
REQ-007 addr  input  16  byte address; sampled with req.
REQ-008 wdata  input  16  store data; sampled with req.
REQ-009 busy  output  1  registered; 1 from the cycle after acceptance until done clears.
REQ-010 done  output  1  registered one-cycle completion pulse.
REQ-011 rdata  output  16  registered load result; holds until the next load completes.
REQ-012 mem_write  output  1  memory strobe A.
REQ-013 mem_read  output  1  memory strobe B.
REQ-014 mem_addr  output  16  memory byte address.
REQ-015 mem_wdata  output  16  memory store data: [7:0] goes to mem_addr, [15:8] goes to mem_addr+1.
REQ-016 mem_rdata  input  16  memory read data; valid one cycle after the load strobe cycle.

Function
REQ-017 Bus encoding SHALL be: idle = mem_write=0, mem_read=0; store = mem_write=0, mem_read=1; load = mem_write=1, mem_read=0; mem_write=1, mem_read=1 SHALL never be driven.
REQ-018 All memory-side outputs SHALL be registered.
REQ-019 Strobes SHALL be active for exactly one cycle per memory access.
REQ-020 States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RMW_RD, RMW_WAIT, RMW_WR, DONE.
REQ-021 IDLE: when req=1, the block SHALL latch we, byte_op, addr and wdata.
REQ-022 IDLE transitions SHALL be: load -> RD_ISSUE; word store -> WR_ISSUE; byte store -> RMW_RD.
REQ-023 RD_ISSUE SHALL drive the load encoding with mem_addr=latched addr, then go to RD_WAIT.
REQ-024 RD_WAIT SHALL capture mem_rdata into rdata, then go to DONE.
REQ-025 A byte load SHALL return rdata={8'h00, mem_rdata[7:0]}.
REQ-026 WR_ISSUE SHALL drive the store encoding with mem_wdata=wdata, then go to DONE.
REQ-027 The byte-store sequence SHALL be RMW_RD (load strobe) -> RMW_WAIT (merge) -> RMW_WR (store strobe) -> DONE.
REQ-028 The RMW merge SHALL write mem_wdata={mem_rdata[15:8], wdata[7:0]}.
REQ-029 DONE SHALL pulse done=1 for one cycle, then return to IDLE with busy=0.
REQ-030 Latency from the acceptance edge to done=1 SHALL be: word store 2 cycles, load 3 cycles, byte store 4 cycles.
REQ-031 A req arriving while busy=1 or in DONE SHALL be ignored, not queued; the requester holds req until busy falls.
REQ-032 A back-to-back req SHALL be accepted in the cycle after DONE.
REQ-033 Address 16'hFFFF SHALL be passed through unchanged; wrap of addr+1 is the memory's concern.

Reset
REQ-034 rst=1 SHALL asynchronously force: state=IDLE, busy=0, done=0, rdata=16'h0000, mem_write=0, mem_read=0, mem_addr=16'h0000, mem_wdata=16'h0000.
REQ-035 Reset mid-operation SHALL abort the access with no strobe and no done pulse.
REQ-036 req sampled in the first clk edge after rst deasserts SHALL be accepted normally.

Configuration
REQ-037 Macro BYTE_LANE_EN SHALL control byte access.
REQ-038 With BYTE_LANE_EN defined: byte_op SHALL behave as specified in REQ-022, REQ-025, REQ-027, REQ-028 and REQ-030.
REQ-039 Without BYTE_LANE_EN: byte_op SHALL be ignored; all accesses are word accesses; RMW states SHALL be absent.

Verification
REQ-040 Load test: memory preloaded with 0x0000=CD, 0x0001=2B; load addr 16'h0000 -> rdata=16'h2BCD, done 3 cycles after acceptance, exactly one load-encoded strobe.
REQ-041 Word store/load test: store wdata=16'hA55A to addr 16'h0010, then load 16'h0010 -> rdata=16'hA55A, store strobe exactly one cycle.
REQ-042 Byte store test (BYTE_LANE_EN): word 16'h1234 at 16'h0020; byte store wdata=16'hxx99 -> word reads 16'h1299, done 4 cycles after acceptance.
REQ-043 Busy test: req held high through a load, second request changes addr -> second request accepted only after DONE, no overlapping strobes.
REQ-044 Reset test: assert rst during RD_WAIT -> strobes 0 immediately, rdata=16'h0000, no done pulse, next req served normally.
REQ-045 Strobe check across all tests: mem_write=1 and mem_read=1 SHALL never be driven in the same cycle.
